// File: rtl/occamy_ecc_scrubber_pkg.sv
// Shared types and constants for the Occamy SRAM ECC scrubber.
package occamy_ecc_scrubber_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWait  = 3'd1,
        StRead  = 3'd2,
        StResp  = 3'd3,
        StWrite = 3'd4
    } scrub_state_e;

    // Bit positions inside mem_rerror_i / event_ecc_rerror_o.
    localparam int unsigned RerrCorrIdx   = 0;
    localparam int unsigned RerrUncorrIdx = 1;

    localparam logic [31:0] CountMax = 32'hFFFF_FFFF;

endpackage

// File: rtl/occamy_ecc_scrub_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module occamy_ecc_scrub_sat_cnt
    import occamy_ecc_scrubber_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
        end else if (inc_i && (count_o != CountMax)) begin
            count_o <= count_o + 32'd1;
        end
    end

endmodule

// File: rtl/occamy_ecc_scrubber.sv
// Background ECC scrubber: walks the bank reading one word per interval, counts errors
// and, with OCCAMY_ECC_SCRUB_WRITEBACK_EN defined, writes corrected data back.
module occamy_ecc_scrubber
    import occamy_ecc_scrubber_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 scrub_en_i,
    input  logic [15:0]          scrub_interval_i,
    input  logic                 host_req_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i,
    input  logic [1:0]           mem_rerror_i,
    output logic [1:0]           event_ecc_rerror_o,
    output logic [31:0]          corr_count_o,
    output logic [31:0]          uncorr_count_o,
    output logic                 busy_o
);

    localparam logic [2:0] IDLE  = StIdle;
    localparam logic [2:0] WAIT  = StWait;
    localparam logic [2:0] READ  = StRead;
    localparam logic [2:0] RESP  = StResp;
    localparam logic [2:0] WRITE = StWrite;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [15:0]          interval_q, interval_d;
    logic [1:0]           event_q, event_d;
    logic                 granted;
    logic                 rsp_valid;
    logic                 rsp_corr;
    logic                 rsp_uncorr;
    logic                 advance;

    // Uncorrectable dominates: a response flagging both bits is never treated as correctable.
    assign rsp_valid  = (state_q == RESP) && mem_rvalid_i;
    assign rsp_uncorr = rsp_valid && mem_rerror_i[RerrUncorrIdx];
    assign rsp_corr   = rsp_valid && mem_rerror_i[RerrCorrIdx] && !mem_rerror_i[RerrUncorrIdx];

    assign mem_req_o          = ((state_q == READ) || (state_q == WRITE)) && !host_req_i;
    assign granted            = mem_req_o && mem_gnt_i;
    assign mem_addr_o         = addr_q;
    assign busy_o             = (state_q != IDLE);
    assign event_ecc_rerror_o = event_q;
    assign event_d            = {rsp_uncorr, rsp_corr};

`ifdef OCCAMY_ECC_SCRUB_WRITEBACK_EN
    localparam bit WbEn = 1'b1;
    logic [DataWidth-1:0] wdata_q;

    // NOTE: only control and datapath flops are reset here; there is no memory array in this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdata_q <= '0;
        end else if (rsp_corr) begin
            wdata_q <= mem_rdata_i;
        end
    end

    assign mem_we_o    = (state_q == WRITE) && !host_req_i;
    assign mem_wdata_o = wdata_q;
`else
    localparam bit WbEn = 1'b0;
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata_i;
    assign mem_we_o     = 1'b0;
    assign mem_wdata_o  = '0;
`endif

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        interval_d = interval_q;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (scrub_en_i) begin
                    state_d    = WAIT;
                    interval_d = scrub_interval_i;
                end
            end
            WAIT: begin
                if (!scrub_en_i) begin
                    state_d = IDLE;
                end else if (interval_q == '0) begin
                    state_d = READ;
                end else begin
                    interval_d = interval_q - 16'd1;
                end
            end
            READ: begin
                // A granted read must complete even if the enable has just dropped.
                if (granted) begin
                    state_d = RESP;
                end else if (!scrub_en_i) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (mem_rvalid_i) begin
                    if (rsp_corr && WbEn) begin
                        state_d = WRITE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (granted) begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            addr_d     = (addr_q == LastAddr) ? '0 : addr_q + AddrWidth'(1);
            state_d    = scrub_en_i ? WAIT : IDLE;
            interval_d = scrub_interval_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            interval_q <= '0;
            event_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            interval_q <= interval_d;
            event_q    <= event_d;
        end
    end

    occamy_ecc_scrub_sat_cnt u_corr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (rsp_corr),
        .count_o (corr_count_o)
    );

    occamy_ecc_scrub_sat_cnt u_uncorr_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (rsp_uncorr),
        .count_o (uncorr_count_o)
    );

endmodule

// File: tb/tb_occamy_ecc_scrubber.sv
// Scoreboard bench for occamy_ecc_scrubber: a default-size bank and a 4-word bank for wrap-around.
`timescale 1ns/1ps
module tb_occamy_ecc_scrubber;

    localparam int DW = 64;
    localparam int NW = 1024;
    localparam int AW = 10;
`ifdef OCCAMY_ECC_SCRUB_WRITEBACK_EN
    localparam bit WbEn = 1'b1;
`else
    localparam bit WbEn = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cyc;
    } acc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scrub_en = 1'b0;
    logic [15:0]   scrub_interval = '0;
    logic          host_req = 1'b0;
    logic          gnt_en = 1'b1;
    logic          mem_req, mem_we, mem_gnt, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    mem_rerror = '0;
    logic [1:0]    ev;
    logic [31:0]   corr_cnt, uncorr_cnt;

    logic          scrub_en4 = 1'b0;
    logic          req4, we4, busy4;
    logic [1:0]    addr4;
    logic [DW-1:0] wdata4;
    logic          rvalid4 = 1'b0;
    logic [1:0]    ev4;
    logic [31:0]   corr4, uncorr4;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int ev0_n, ev1_n, ev0_cyc;
    acc_t exp_q[$];
    acc_t obs_q[$];
    int   exp4_q[$];
    int   obs4_q[$];
    logic [1:0]    err_tbl [NW];
    logic [DW-1:0] data_tbl[NW];

    always #5 clk = ~clk;
    assign mem_gnt = gnt_en;

    occamy_ecc_scrubber dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .scrub_en_i         (scrub_en),
        .scrub_interval_i   (scrub_interval),
        .host_req_i         (host_req),
        .mem_req_o          (mem_req),
        .mem_we_o           (mem_we),
        .mem_addr_o         (mem_addr),
        .mem_wdata_o        (mem_wdata),
        .mem_gnt_i          (mem_gnt),
        .mem_rvalid_i       (mem_rvalid),
        .mem_rdata_i        (mem_rdata),
        .mem_rerror_i       (mem_rerror),
        .event_ecc_rerror_o (ev),
        .corr_count_o       (corr_cnt),
        .uncorr_count_o     (uncorr_cnt),
        .busy_o             (busy)
    );

    occamy_ecc_scrubber #(.NumWords(4)) dut4 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .scrub_en_i         (scrub_en4),
        .scrub_interval_i   (16'd0),
        .host_req_i         (1'b0),
        .mem_req_o          (req4),
        .mem_we_o           (we4),
        .mem_addr_o         (addr4),
        .mem_wdata_o        (wdata4),
        .mem_gnt_i          (1'b1),
        .mem_rvalid_i       (rvalid4),
        .mem_rdata_i        (64'h0),
        .mem_rerror_i       (2'b00),
        .event_ecc_rerror_o (ev4),
        .corr_count_o       (corr4),
        .uncorr_count_o     (uncorr4),
        .busy_o             (busy4)
    );

    // Monitor: samples pre-edge values at each rising edge.
    always @(posedge clk) begin
        cycle++;
        if (mem_req && mem_gnt)
            obs_q.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata, cyc: cycle});
        if (ev[0]) begin ev0_n++; ev0_cyc = cycle; end
        if (ev[1]) ev1_n++;
        if (req4) obs4_q.push_back(int'(addr4));
    end

    // Bank model: one read response in the cycle after each granted read.
    always begin : responder
        logic          fire, fire4;
        logic [AW-1:0] raddr;
        @(posedge clk);
        fire  = mem_req && mem_gnt && !mem_we;
        raddr = mem_addr;
        fire4 = req4 && !we4;
        @(negedge clk);
        mem_rvalid = fire;
        mem_rdata  = fire ? data_tbl[raddr] : '0;
        mem_rerror = fire ? err_tbl[raddr] : 2'b00;
        rvalid4    = fire4;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        ev0_n = 0;
        ev1_n = 0;
    endtask

    task automatic test_reset;
        logic [DW+AW+70:0] flat;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        flat = {mem_req, mem_we, mem_addr, mem_wdata, ev, corr_cnt, uncorr_cnt, busy};
        checks++;
        if (flat !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected all zero", flat);
        end
        checks++;
        if ({req4, we4, addr4, ev4, corr4, uncorr4, busy4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs4: req %b addr %0d busy %b, expected zero", req4, addr4, busy4);
        end
        rst_n = 1'b1;
        ev0_n = 0;
        ev1_n = 0;
        obs_q.delete();
        obs4_q.delete();
    endtask

    task automatic test_interval;
        acc_t e, o;
        bit   ok;
        int   cyc[3];
        int   k = 0;
        scrub_interval = 16'd3;
        for (int a = 0; a < 3; a++) exp_q.push_back('{we: 1'b0, addr: AW'(a), wdata: '0, cyc: 0});
        scrub_en = 1'b1;
        wait_obs(3, ok);
        scrub_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL interval_timeout: %0d accesses, expected 3", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL interval_access: no access seen, expected read addr %0d", e.addr);
            end else begin
                o = obs_q.pop_front();
                cyc[k] = o.cyc;
                k++;
                if (o.we !== e.we || o.addr !== e.addr) begin
                    errors++;
                    $display("FAIL interval_access: got we %b addr %0d, expected we %b addr %0d", o.we, o.addr, e.we, e.addr);
                end
            end
        end
        for (int i = 1; i < k; i++) begin
            checks++;
            if (cyc[i] - cyc[i-1] !== 6) begin
                errors++;
                $display("FAIL interval_spacing: got %0d cycles, expected 6", cyc[i] - cyc[i-1]);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL interval_stop: busy %b extra accesses %0d, expected 0 and 0", busy, obs_q.size());
        end
    endtask

    task automatic test_host_priority;
        acc_t o;
        bit   ok;
        bit   leaked = 1'b0;
        int   drop_cyc;
        scrub_interval = 16'd0;
        host_req = 1'b1;
        scrub_en = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (mem_req !== 1'b0) leaked = 1'b1;
        end
        checks++;
        if (leaked || busy !== 1'b1) begin
            errors++;
            $display("FAIL host_block: req leaked %b busy %b, expected 0 and 1", leaked, busy);
        end
        host_req = 1'b0;
        drop_cyc = cycle;
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== AW'(3)) begin
            errors++;
            $display("FAIL host_release: req %b addr %0d, expected 1 and 3", mem_req, mem_addr);
        end
        wait_obs(1, ok);
        scrub_en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL host_grant: no read observed, expected addr 3");
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== AW'(3) || o.we !== 1'b0 || o.cyc !== drop_cyc + 1) begin
                errors++;
                $display("FAIL host_grant: got addr %0d we %b cyc %0d, expected 3 0 %0d", o.addr, o.we, o.cyc, drop_cyc + 1);
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_correctable;
        acc_t e, o;
        bit   ok;
        int   idx = 0;
        int   rd5_cyc = -100;
        err_tbl[5]  = 2'b01;
        data_tbl[5] = 64'hDEAD;
        ev0_n = 0;
        ev1_n = 0;
        exp_q.push_back('{we: 1'b0, addr: AW'(4), wdata: '0, cyc: 0});
        exp_q.push_back('{we: 1'b0, addr: AW'(5), wdata: '0, cyc: 0});
        if (WbEn) exp_q.push_back('{we: 1'b1, addr: AW'(5), wdata: 64'hDEAD, cyc: 0});
        scrub_en = 1'b1;
        wait_obs(WbEn ? 3 : 2, ok);
        scrub_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL corr_timeout: %0d accesses observed", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL corr_access: no access seen, expected we %b addr %0d", e.we, e.addr);
            end else begin
                o = obs_q.pop_front();
                if (idx == 1) rd5_cyc = o.cyc;
                idx++;
                if (o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL corr_access: got we %b addr %0d wdata %h, expected we %b addr %0d wdata %h",
                             o.we, o.addr, o.wdata, e.we, e.addr, e.wdata);
                end
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (corr_cnt !== 32'd1 || uncorr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL corr_counts: got corr %0d uncorr %0d, expected 1 0", corr_cnt, uncorr_cnt);
        end
        checks++;
        if (ev0_n !== 1 || ev0_cyc !== rd5_cyc + 2 || ev1_n !== 0) begin
            errors++;
            $display("FAIL corr_event: got %0d pulses at cyc %0d (uncorr %0d), expected 1 at %0d (0)",
                     ev0_n, ev0_cyc, ev1_n, rd5_cyc + 2);
        end
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL corr_stop: extra accesses %0d busy %b, expected 0 0", obs_q.size(), busy);
        end
        err_tbl[5] = 2'b00;
    endtask

    task automatic test_uncorrectable;
        acc_t o;
        bit   ok;
        apply_reset();
        err_tbl[0] = 2'b11;
        scrub_en = 1'b1;
        wait_obs(1, ok);
        scrub_en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL uncorr_access: no access seen, expected read addr 0");
        end else begin
            o = obs_q.pop_front();
            if (o.we !== 1'b0 || o.addr !== AW'(0)) begin
                errors++;
                $display("FAIL uncorr_access: got we %b addr %0d, expected 0 0", o.we, o.addr);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (uncorr_cnt !== 32'd1 || corr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL uncorr_counts: got uncorr %0d corr %0d, expected 1 0", uncorr_cnt, corr_cnt);
        end
        checks++;
        if (ev1_n !== 1 || ev0_n !== 0) begin
            errors++;
            $display("FAIL uncorr_event: got uncorr pulses %0d corr pulses %0d, expected 1 0", ev1_n, ev0_n);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL uncorr_nowrite: got %0d extra accesses, expected 0", obs_q.size());
        end
        err_tbl[0] = 2'b00;
    endtask

    task automatic test_abort;
        acc_t o;
        bit   ok;
        err_tbl[1]  = 2'b01;
        data_tbl[1] = 64'h1234;
        scrub_en = 1'b1;
        wait_obs(1, ok);
        scrub_en = 1'b0;
        gnt_en   = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_read: no access seen, expected read addr 1");
        end else begin
            o = obs_q.pop_front();
            if (o.addr !== AW'(1) || o.we !== 1'b0) begin
                errors++;
                $display("FAIL abort_read: got we %b addr %0d, expected 0 1", o.we, o.addr);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== WbEn || mem_we !== WbEn) begin
            errors++;
            $display("FAIL abort_finish: busy %b we %b, expected %b %b", busy, mem_we, WbEn, WbEn);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, ev, corr_cnt, uncorr_cnt, busy} !== '0) begin
            errors++;
            $display("FAIL abort_reset: req %b we %b addr %0d busy %b corr %0d, expected all zero",
                     mem_req, mem_we, mem_addr, busy, corr_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        gnt_en = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0 || mem_addr !== AW'(0)) begin
            errors++;
            $display("FAIL abort_nowrite: accesses %0d busy %b addr %0d, expected 0 0 0", obs_q.size(), busy, mem_addr);
        end
        err_tbl[1] = 2'b00;
    endtask

    task automatic test_wrap;
        bit ok = 1'b0;
        int e, o;
        for (int i = 0; i < 9; i++) exp4_q.push_back(i % 4);
        obs4_q.delete();
        scrub_en4 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (obs4_q.size() >= 9) begin ok = 1'b1; break; end
        end
        scrub_en4 = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_timeout: %0d reads, expected 9", obs4_q.size()); end
        while (exp4_q.size() > 0) begin
            e = exp4_q.pop_front();
            checks++;
            if (obs4_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_addr: no read seen, expected %0d", e);
            end else begin
                o = obs4_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL wrap_addr: got %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            err_tbl[i]  = 2'b00;
            data_tbl[i] = {32'hC0DE_0000, 32'(i)};
        end
        test_reset();
        test_interval();
        test_host_priority();
        test_correctable();
        test_uncorrectable();
        test_abort();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
